// File: rtl/serial_out_if.sv
// Bundle between the transmit controller/RAM side (master) and the serial_out
// transmitter (slave): start/config request, RAM read port, serial line and status.
interface serial_out_if #(
  parameter int ADDR_WIDTH   = 12,
  parameter int MAX_FEATURES = 15,
  parameter int LENGTH       = 16,
  parameter int DATA_WIDTH   = LENGTH * (MAX_FEATURES + 1)
) ();
  logic                  start;
  logic [3:0]            feat;
  logic [ADDR_WIDTH-1:0] num_dp;
  logic [DATA_WIDTH-1:0] data;
  logic [ADDR_WIDTH-1:0] addr;
  logic                  oe;
  logic                  ser;
  logic                  busy;
  logic                  done;

  modport master (
    output start, feat, num_dp, data,
    input  addr, oe, ser, busy, done
  );

  modport slave (
    input  start, feat, num_dp, data,
    output addr, oe, ser, busy, done
  );
endinterface

// File: rtl/serial_out.sv
// Row-RAM serial transmitter: fetches each row, then sends fields 0..feat as
// start/data(MSB first)/stop words. Define SER_OUT_PARITY_EN to add an even-parity bit.
module serial_out #(
  parameter int ADDR_WIDTH   = 12,
  parameter int MAX_FEATURES = 15,
  parameter int LENGTH       = 16,
  parameter int DATA_WIDTH   = LENGTH * (MAX_FEATURES + 1)
) (
  input  logic CLK,
  input  logic RST,
  serial_out_if.slave bus
);

`ifdef SER_OUT_PARITY_EN
  localparam int W = LENGTH + 3;
`else
  localparam int W = LENGTH + 2;
`endif
  localparam int NF = MAX_FEATURES + 1;
  localparam int BW = $clog2(W);
  localparam logic [BW-1:0] DATA_LAST = BW'(LENGTH);
  localparam logic [BW-1:0] LAST_BIT  = BW'(W - 1);
`ifdef SER_OUT_PARITY_EN
  localparam logic [BW-1:0] PAR_BIT   = BW'(LENGTH + 1);
`endif

  typedef enum logic [1:0] {IDLE, FETCH, SHIFT, FIN} state_t;

  state_t                state_q, state_d;
  logic [3:0]            feat_q, feat_d;
  logic [ADDR_WIDTH-1:0] num_dp_q, num_dp_d;
  logic [ADDR_WIDTH-1:0] row_cnt_q, row_cnt_d;
  logic [3:0]            field_q, field_d;
  logic [BW-1:0]         bit_q, bit_d;
  logic [DATA_WIDTH-1:0] row_q, row_d;
  logic                  ser_q, ser_d;
  logic                  oe_q, oe_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;

  logic [LENGTH-1:0] field_words [NF];
  logic [LENGTH-1:0] word;
  logic [LENGTH-1:0] shifted;

  // Field views of the next row value, so outputs can be registered from next state.
  for (genvar gi = 0; gi < NF; gi++) begin : g_fields
    assign field_words[gi] = row_d[gi*LENGTH +: LENGTH];
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q   <= IDLE;
      feat_q    <= '0;
      num_dp_q  <= '0;
      row_cnt_q <= '0;
      field_q   <= '0;
      bit_q     <= '0;
      row_q     <= '0;
      ser_q     <= 1'b1;
      oe_q      <= 1'b0;
      addr_q    <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      feat_q    <= feat_d;
      num_dp_q  <= num_dp_d;
      row_cnt_q <= row_cnt_d;
      field_q   <= field_d;
      bit_q     <= bit_d;
      row_q     <= row_d;
      ser_q     <= ser_d;
      oe_q      <= oe_d;
      addr_q    <= addr_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    feat_d    = feat_q;
    num_dp_d  = num_dp_q;
    row_cnt_d = row_cnt_q;
    field_d   = field_q;
    bit_d     = bit_q;
    row_d     = row_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          feat_d    = bus.feat;
          num_dp_d  = bus.num_dp;
          row_cnt_d = '0;
          field_d   = '0;
          bit_d     = '0;
          state_d   = (bus.num_dp == '0) ? FIN : FETCH;
        end
      end
      FETCH: begin
        row_d   = bus.data;
        field_d = '0;
        bit_d   = '0;
        state_d = SHIFT;
      end
      SHIFT: begin
        if (bit_q == LAST_BIT) begin
          bit_d = '0;
          if (field_q == feat_q) begin
            field_d = '0;
            if (row_cnt_q + 1'b1 < num_dp_q) begin
              row_cnt_d = row_cnt_q + 1'b1;
              state_d   = FETCH;
            end else begin
              state_d = FIN;
            end
          end else begin
            field_d = field_q + 1'b1;
          end
        end else begin
          bit_d = bit_q + 1'b1;
        end
      end
      // An empty transfer enters FIN with done_q low and waits one cycle for its pulse.
      FIN: begin
        if (done_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    word    = field_words[field_d];
    shifted = word << (bit_d - 1'b1);
    ser_d   = 1'b1;
    if (state_d == SHIFT) begin
      if (bit_d == '0) begin
        ser_d = 1'b0;
      end else if (bit_d <= DATA_LAST) begin
        ser_d = shifted[LENGTH-1];
`ifdef SER_OUT_PARITY_EN
      end else if (bit_d == PAR_BIT) begin
        ser_d = ^word;
`endif
      end
    end
    oe_d   = (state_d == FETCH);
    addr_d = (state_d == FETCH) ? row_cnt_d : addr_q;
    busy_d = (state_d != IDLE);
    done_d = (state_d == FIN) && (state_q != IDLE);
  end

  assign bus.ser  = ser_q;
  assign bus.oe   = oe_q;
  assign bus.addr = addr_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;

endmodule

// File: tb/tb_serial_out.sv
// Scoreboard bench for serial_out: stimulus queues expected fetches, words and
// done cycles; a negedge monitor decodes the serial line and compares.
module tb_serial_out;
  localparam int AW = 12;
  localparam int MF = 15;
  localparam int L  = 16;
  localparam int DW = L * (MF + 1);
`ifdef SER_OUT_PARITY_EN
  localparam int W = L + 3;
`else
  localparam int W = L + 2;
`endif

  logic CLK = 1'b0;
  logic RST = 1'b0;
  always #5 CLK = ~CLK;

  serial_out_if #(.ADDR_WIDTH(AW), .MAX_FEATURES(MF), .LENGTH(L), .DATA_WIDTH(DW)) ifc ();

  serial_out #(.ADDR_WIDTH(AW), .MAX_FEATURES(MF), .LENGTH(L), .DATA_WIDTH(DW)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (ifc)
  );

  logic [DW-1:0] mem [0:7];
  assign ifc.data = mem[ifc.addr[2:0]];

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {int addr; int cyc;} fetch_t;
  fetch_t       exp_fetch[$];
  logic [L-1:0] exp_word[$];
  int           exp_done[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor
  bit           in_frame = 1'b0;
  int           bitn;
  logic [L-1:0] w;
  logic [L-1:0] ew;
  logic         par;
  fetch_t       f;
  int           dc;

  always @(negedge CLK) begin
    if (!RST) begin
      in_frame = 1'b0;
    end else begin
      if (ifc.oe === 1'b1) begin
        if (exp_fetch.size() == 0) begin
          checks++; errors++;
          $display("FAIL fetch_unexpected: addr %0d at cycle %0d, none required", ifc.addr, cyc);
        end else begin
          f = exp_fetch.pop_front();
          check("fetch_addr", 64'(ifc.addr), 64'(f.addr));
          check("fetch_cycle", 64'(cyc), 64'(f.cyc));
        end
      end
      if (ifc.done === 1'b1) begin
        check("done_busy", 64'(ifc.busy), 64'd1);
        if (exp_done.size() == 0) begin
          checks++; errors++;
          $display("FAIL done_unexpected: done at cycle %0d, none required", cyc);
        end else begin
          dc = exp_done.pop_front();
          check("done_cycle", 64'(cyc), 64'(dc));
        end
      end
      if (!in_frame) begin
        if (ifc.ser !== 1'b1) begin
          in_frame = 1'b1;
          bitn = 0;
          w = '0;
        end
      end else begin
        bitn++;
        if (bitn <= L) begin
          w = {w[L-2:0], ifc.ser};
`ifdef SER_OUT_PARITY_EN
        end else if (bitn == L + 1) begin
          par = ifc.ser;
`endif
        end else begin
          in_frame = 1'b0;
          check("stop_bit", 64'(ifc.ser), 64'd1);
          if (exp_word.size() == 0) begin
            checks++; errors++;
            $display("FAIL word_unexpected: got %0h, none required", w);
          end else begin
            ew = exp_word.pop_front();
            check("word", 64'(w), 64'(ew));
            $display("word %04h (required %04h) at cycle %0d", w, ew, cyc);
`ifdef SER_OUT_PARITY_EN
            check("parity", 64'(par), 64'(^ew));
`endif
          end
        end
      end
    end
  end

  task automatic begin_xfer(input int n, input int fe);
    int p, e0;
    @(negedge CLK);
    e0 = cyc + 1;
    p  = 1 + (fe + 1) * W;
    for (int r = 0; r < n; r++) begin
      exp_fetch.push_back('{addr: r, cyc: e0 + r * p});
      for (int k = 0; k <= fe; k++) exp_word.push_back(mem[r][k*L +: L]);
    end
    exp_done.push_back((n == 0) ? e0 + 1 : e0 + n * p);
    ifc.num_dp = AW'(n);
    ifc.feat   = 4'(fe);
    ifc.start  = 1'b1;
    @(negedge CLK);
    ifc.start  = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int t = 0;
    while (exp_done.size() != 0 && t < budget) begin
      @(negedge CLK);
      t++;
    end
    if (exp_done.size() != 0) begin
      checks++; errors++;
      $display("FAIL done_timeout: no done within %0d cycles", budget);
      exp_done.delete(); exp_word.delete(); exp_fetch.delete();
    end
    repeat (3) @(negedge CLK);
    check("queues_drained", 64'(exp_word.size() + exp_fetch.size()), 64'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    ifc.start  = 1'b0;
    ifc.feat   = '0;
    ifc.num_dp = '0;
    for (int i = 0; i < 8; i++) mem[i] = '0;

    repeat (3) @(negedge CLK);
    check("rst_ser",  64'(ifc.ser),  64'd1);
    check("rst_oe",   64'(ifc.oe),   64'd0);
    check("rst_addr", 64'(ifc.addr), 64'd0);
    check("rst_busy", 64'(ifc.busy), 64'd0);
    check("rst_done", 64'(ifc.done), 64'd0);
    RST = 1'b1;
    @(negedge CLK);

    // Single row
    mem[0][15:0] = 16'hA5C3;
    begin_xfer(1, 0);
    wait_done(100);

    // Multi-row; config changes after start must not matter
    mem[0][15:0] = 16'h0001; mem[0][31:16] = 16'h8000;
    mem[1][15:0] = 16'h1234; mem[1][31:16] = 16'hFFFF;
    mem[2][15:0] = 16'h0000; mem[2][31:16] = 16'h7FFF;
    begin_xfer(3, 1);
    ifc.feat   = 4'd0;
    ifc.num_dp = '0;
    wait_done(300);

    // Empty transfer
    begin_xfer(0, 0);
    wait_done(20);

    // Start while busy, then reset mid-word
    for (int i = 0; i < 8; i++) mem[i] = '0;
    mem[0][15:0] = 16'hBEEF;
    begin_xfer(1, 0);
    repeat (6) @(negedge CLK);
    ifc.start = 1'b1;
    @(negedge CLK);
    ifc.start = 1'b0;
    repeat (3) @(negedge CLK);
    #2 RST = 1'b0;
    #1;
    check("midrst_ser",  64'(ifc.ser),  64'd1);
    check("midrst_busy", 64'(ifc.busy), 64'd0);
    check("midrst_done", 64'(ifc.done), 64'd0);
    check("midrst_oe",   64'(ifc.oe),   64'd0);
    exp_word.delete(); exp_done.delete(); exp_fetch.delete();
    repeat (2) @(negedge CLK);
    RST = 1'b1;
    begin_xfer(1, 0);
    wait_done(100);

    // Full width
    for (int k = 0; k < 16; k++) mem[0][k*L +: L] = 16'((k << 8) | k);
    begin_xfer(1, 15);
    wait_done(400);

    // Parity vectors (plain words without the parity macro)
    for (int i = 0; i < 8; i++) mem[i] = '0;
    mem[0][15:0] = 16'h0007;
    mem[1][15:0] = 16'h0003;
    begin_xfer(2, 0);
    wait_done(100);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
